// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_pkg
// Description : Shared opcodes, register strobe encodings and FSM states for
//               the ENTER/LEAVE stack-frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_pkg;

    localparam logic [1:0]  OP_ENTER   = 2'b01;
    localparam logic [1:0]  OP_LEAVE   = 2'b10;

    // Strobe encoding consumed by the existing ebp/esp register blocks
    localparam logic [3:0]  RW_NONE    = 4'h0;
    localparam logic [3:0]  RW_WRITE   = 4'h2;

    localparam logic [31:0] STACK_SLOT = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PUSH      = 3'd1,
        ST_SET_FRAME = 3'd2,
        ST_SET_ESP   = 3'd3,
        ST_POP       = 3'd4,
        ST_RESTORE   = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_sequencer_if
// Description : Single-request data-memory handshake used for the push/pop of
//               the saved frame pointer.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_sequencer_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_sequencer
// Description : Multi-cycle ENTER/LEAVE controller driving the ebp/esp write
//               strobes and the frame-pointer push/pop memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer
    import frame_pkg::*;
(
    input  wire         clock_5,
    input  wire         reset,
    input  wire         start,
    input  wire  [1:0]  op,
    input  wire  [15:0] frame_size,
    input  wire  [31:0] esp_in,
    input  wire  [31:0] ebp_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  ebp_rw,
    output logic [31:0] ebp_wdata,
    output logic [3:0]  esp_rw,
    output logic [31:0] esp_wdata,
    frame_sequencer_if.master mem
);

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_esp_q;
    logic [31:0] r_ebp_q;
    logic [15:0] r_fs_q;
    logic [31:0] r_pop_q;

    logic        w_accept;
    logic [31:0] w_esp_q_nxt;
    logic [31:0] w_ebp_q_nxt;
    logic [15:0] w_fs_q_nxt;
    logic [31:0] w_pop_q_nxt;
    logic [31:0] w_frame_ptr;

    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_ebp_rw;
    logic [31:0] r_ebp_wdata;
    logic [3:0]  r_esp_rw;
    logic [31:0] r_esp_wdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic        w_busy;
    logic        w_done;
    logic [3:0]  w_ebp_rw;
    logic [31:0] w_ebp_wdata;
    logic [3:0]  w_esp_rw;
    logic [31:0] w_esp_wdata;
    logic        w_mem_req;
    logic        w_mem_we;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_wdata;

    // State, latched operands and registered outputs
    always_ff @(posedge clock_5 or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_esp_q     <= 32'd0;
            r_ebp_q     <= 32'd0;
            r_fs_q      <= 16'd0;
            r_pop_q     <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ebp_rw    <= RW_NONE;
            r_ebp_wdata <= 32'd0;
            r_esp_rw    <= RW_NONE;
            r_esp_wdata <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_esp_q     <= w_esp_q_nxt;
            r_ebp_q     <= w_ebp_q_nxt;
            r_fs_q      <= w_fs_q_nxt;
            r_pop_q     <= w_pop_q_nxt;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_ebp_rw    <= w_ebp_rw;
            r_ebp_wdata <= w_ebp_wdata;
            r_esp_rw    <= w_esp_rw;
            r_esp_wdata <= w_esp_wdata;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (op == OP_ENTER || op == OP_LEAVE)) begin
                    w_accept     = 1'b1;
                    w_state_next = (op == OP_ENTER) ? ST_PUSH : ST_SET_ESP;
                end
            end
            ST_PUSH:      if (mem.mem_ack) w_state_next = ST_SET_FRAME;
            ST_SET_FRAME: w_state_next = ST_DONE;
            ST_SET_ESP:   w_state_next = ST_POP;
            ST_POP:       if (mem.mem_ack) w_state_next = ST_RESTORE;
            ST_RESTORE:   w_state_next = ST_DONE;
            ST_DONE:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase

        w_esp_q_nxt = w_accept ? esp_in     : r_esp_q;
        w_ebp_q_nxt = w_accept ? ebp_in     : r_ebp_q;
        w_fs_q_nxt  = w_accept ? frame_size : r_fs_q;
        w_pop_q_nxt = (r_state == ST_POP && mem.mem_ack) ? mem.mem_rdata : r_pop_q;
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they belong to.
    always_comb begin
        w_frame_ptr = w_esp_q_nxt - STACK_SLOT;
        w_busy      = (w_state_next != ST_IDLE);
        w_done      = (w_state_next == ST_DONE);
        w_ebp_rw    = RW_NONE;
        w_ebp_wdata = r_ebp_wdata;
        w_esp_rw    = RW_NONE;
        w_esp_wdata = r_esp_wdata;
        w_mem_req   = 1'b0;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        case (w_state_next)
            ST_PUSH: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_frame_ptr;
                w_mem_wdata = w_ebp_q_nxt;
            end
            ST_SET_FRAME: begin
                w_ebp_rw    = RW_WRITE;
                w_ebp_wdata = w_frame_ptr;
                w_esp_rw    = RW_WRITE;
                w_esp_wdata = w_frame_ptr - {16'd0, w_fs_q_nxt};
            end
            ST_SET_ESP: begin
                w_esp_rw    = RW_WRITE;
                w_esp_wdata = w_ebp_q_nxt;
            end
            ST_POP: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b0;
                w_mem_addr  = w_ebp_q_nxt;
            end
            ST_RESTORE: begin
                w_ebp_rw    = RW_WRITE;
                w_ebp_wdata = w_pop_q_nxt;
                w_esp_rw    = RW_WRITE;
                w_esp_wdata = w_ebp_q_nxt + STACK_SLOT;
            end
            default: begin
            end
        endcase
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign ebp_rw        = r_ebp_rw;
    assign ebp_wdata     = r_ebp_wdata;
    assign esp_rw        = r_esp_rw;
    assign esp_wdata     = r_esp_wdata;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sequencer
// Description : Scoreboard bench for frame_sequencer ENTER/LEAVE sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;
    import frame_pkg::*;

    logic        clock_5    = 1'b0;
    logic        reset      = 1'b0;
    logic        start      = 1'b0;
    logic [1:0]  op         = 2'b00;
    logic [15:0] frame_size = 16'd0;
    logic [31:0] esp_in     = 32'd0;
    logic [31:0] ebp_in     = 32'd0;
    logic        busy;
    logic        done;
    logic [3:0]  ebp_rw;
    logic [31:0] ebp_wdata;
    logic [3:0]  esp_rw;
    logic [31:0] esp_wdata;

    frame_sequencer_if mem_if ();

    frame_sequencer u_dut (
        .clock_5    (clock_5),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .frame_size (frame_size),
        .esp_in     (esp_in),
        .ebp_in     (ebp_in),
        .busy       (busy),
        .done       (done),
        .ebp_rw     (ebp_rw),
        .ebp_wdata  (ebp_wdata),
        .esp_rw     (esp_rw),
        .esp_wdata  (esp_wdata),
        .mem        (mem_if.master)
    );

    always #5 clock_5 = ~clock_5;

    typedef struct {
        logic        busy;
        logic        done;
        logic [3:0]  ebp_rw;
        logic [31:0] ebp_wd;
        logic [3:0]  esp_rw;
        logic [31:0] esp_wd;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t blank(input logic b);
        exp_t e;
        e.busy   = b;
        e.done   = 1'b0;
        e.ebp_rw = 4'h0;
        e.ebp_wd = 32'd0;
        e.esp_rw = 4'h0;
        e.esp_wd = 32'd0;
        e.req    = 1'b0;
        e.we     = 1'b0;
        e.addr   = 32'd0;
        e.wdata  = 32'd0;
        e.ack    = 1'b0;
        e.rdata  = 32'd0;
        return e;
    endfunction

    task automatic compare_now(input string tag);
        exp_t e;
        check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, " busy"},   32'(busy),   32'(e.busy));
        check({tag, " done"},   32'(done),   32'(e.done));
        check({tag, " ebp_rw"}, 32'(ebp_rw), 32'(e.ebp_rw));
        check({tag, " esp_rw"}, 32'(esp_rw), 32'(e.esp_rw));
        check({tag, " mem_req"}, 32'(mem_if.mem_req), 32'(e.req));
        if (e.ebp_rw == 4'h2) check({tag, " ebp_wdata"}, ebp_wdata, e.ebp_wd);
        if (e.esp_rw == 4'h2) check({tag, " esp_wdata"}, esp_wdata, e.esp_wd);
        if (e.req) begin
            check({tag, " mem_we"},   32'(mem_if.mem_we), 32'(e.we));
            check({tag, " mem_addr"}, mem_if.mem_addr,   e.addr);
            if (e.we) check({tag, " mem_wdata"}, mem_if.mem_wdata, e.wdata);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"},      32'(busy),            32'd0);
        check({tag, " done"},      32'(done),            32'd0);
        check({tag, " ebp_rw"},    32'(ebp_rw),          32'd0);
        check({tag, " esp_rw"},    32'(esp_rw),          32'd0);
        check({tag, " mem_req"},   32'(mem_if.mem_req),  32'd0);
        check({tag, " mem_we"},    32'(mem_if.mem_we),   32'd0);
        check({tag, " mem_addr"},  mem_if.mem_addr,      32'd0);
        check({tag, " mem_wdata"}, mem_if.mem_wdata,     32'd0);
        check({tag, " ebp_wdata"}, ebp_wdata,            32'd0);
        check({tag, " esp_wdata"}, esp_wdata,            32'd0);
    endtask

    // Called right after a falling edge; builds the expected transcript,
    // then walks it one cycle at a time driving mem_ack per entry.
    task automatic run_op(input logic [1:0] o, input logic [31:0] esp, input logic [31:0] ebp,
                          input logic [15:0] fs, input int d, input logic [31:0] rd,
                          input bit noisy, input string name);
        exp_t e;
        int   n;
        start = 1'b1; op = o; esp_in = esp; ebp_in = ebp; frame_size = fs;
        mem_if.mem_ack = 1'b0;
        if (o == OP_ENTER) begin
            for (int i = 0; i <= d; i++) begin
                e = blank(1'b1); e.req = 1'b1; e.we = 1'b1;
                e.addr = esp - 32'd4; e.wdata = ebp; e.ack = (i == d);
                sb.push_back(e);
            end
            e = blank(1'b1); e.ack = noisy;
            e.ebp_rw = 4'h2; e.ebp_wd = esp - 32'd4;
            e.esp_rw = 4'h2; e.esp_wd = esp - 32'd4 - {16'd0, fs};
            sb.push_back(e);
        end else begin
            e = blank(1'b1); e.ack = noisy; e.esp_rw = 4'h2; e.esp_wd = ebp;
            sb.push_back(e);
            for (int i = 0; i <= d; i++) begin
                e = blank(1'b1); e.req = 1'b1; e.we = 1'b0; e.addr = ebp;
                e.ack = (i == d); e.rdata = rd;
                sb.push_back(e);
            end
            e = blank(1'b1); e.ack = noisy;
            e.ebp_rw = 4'h2; e.ebp_wd = rd;
            e.esp_rw = 4'h2; e.esp_wd = ebp + 32'd4;
            sb.push_back(e);
        end
        e = blank(1'b1); e.done = 1'b1; e.ack = noisy; sb.push_back(e);
        e = blank(1'b0); e.ack = noisy; sb.push_back(e); sb.push_back(e);

        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock_5);
            e = sb[0];
            compare_now($sformatf("%s[%0d]", name, i));
            mem_if.mem_ack   = e.ack;
            mem_if.mem_rdata = !e.ack ? 32'd0 : (e.req ? e.rdata : 32'hDEAD_BEEF);
            if (noisy) begin
                esp_in     = $urandom;
                ebp_in     = $urandom;
                frame_size = 16'($urandom);
            end
            if (!noisy || !e.busy) start = 1'b0;
        end
        mem_if.mem_ack = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        exp_t e;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'd0;

        repeat (3) @(negedge clock_5);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clock_5);

        // Invalid ops and plain idle must not start anything
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = (i < 3) ? 2'b11 : 2'b00;
            @(negedge clock_5);
            sb.push_back(blank(1'b0));
            compare_now($sformatf("invalid_op[%0d]", i));
        end
        start = 1'b0;
        @(negedge clock_5);

        run_op(OP_ENTER, 32'h0000_1000, 32'h0000_2000, 16'h0010, 0, 32'd0, 1'b0, "enter");
        run_op(OP_LEAVE, 32'h0000_0FEC, 32'h0000_0FFC, 16'h0000, 3, 32'h0000_2000, 1'b0, "leave");
        run_op(OP_ENTER, 32'h0000_0002, 32'h0000_1234, 16'h0000, 1, 32'd0, 1'b0, "wrap");
        run_op(OP_ENTER, 32'h4000_0100, 32'h5000_0000, 16'hFFFC, 2, 32'd0, 1'b1, "enter_busy_start");
        run_op(OP_LEAVE, 32'h1111_0000, 32'h2222_0000, 16'h0040, 0, 32'hCAFE_F00D, 1'b1, "leave_busy_start");

        // Reset during a PUSH wait
        start = 1'b1; op = OP_ENTER; esp_in = 32'h0000_8000; ebp_in = 32'h0000_9000; frame_size = 16'd8;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_5);
            start = 1'b0;
            e = blank(1'b1); e.req = 1'b1; e.we = 1'b1; e.addr = 32'h0000_7FFC; e.wdata = 32'h0000_9000;
            sb.push_back(e);
            compare_now($sformatf("rst_push[%0d]", i));
        end
        #2 reset = 1'b0;
        #1 check("rst_async mem_req", 32'(mem_if.mem_req), 32'd0);
        check_reset_values("rst_mid");
        @(negedge clock_5);
        reset = 1'b1;
        @(negedge clock_5);

        run_op(OP_ENTER, 32'h0000_3000, 32'h0000_3100, 16'h0020, 1, 32'd0, 1'b0, "enter_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
